// File: rtl/mmcm_ps_sequencer.sv
// MMCM dynamic phase-shift sequencer: turns absolute/relative phase commands into single
// psen/psdone steps and tracks the resulting phase modulo one output-clock period.
module mmcm_ps_sequencer #(
    parameter int PHASE_W          = 16,
    parameter int STEPS_PER_PERIOD = 448,
    parameter int PSDONE_TIMEOUT   = 32,
    parameter int SETTLE_CYCLES    = 4
) (
    input  logic               psclk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_mode,
    input  logic [PHASE_W-1:0] cmd_value,
    input  logic               locked,
    output logic               psen,
    output logic               psincdec,
    input  logic               psdone,
    output logic [PHASE_W-1:0] phase_pos,
    output logic               busy,
    output logic               done,
    output logic [1:0]         err_code
);
    localparam logic [PHASE_W-1:0] P      = PHASE_W'(STEPS_PER_PERIOD);
    localparam logic [PHASE_W-1:0] P_LAST = PHASE_W'(STEPS_PER_PERIOD - 1);
    localparam logic [PHASE_W-1:0] HALF_P = PHASE_W'(STEPS_PER_PERIOD / 2);
    localparam int TMO_W = $clog2(PSDONE_TIMEOUT + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PSDONE_TIMEOUT - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;
    localparam logic [1:0] ERR_LOCK  = 2'b11;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_IDLE      = 3'd1,
        ST_CALC      = 3'd2,
        ST_PULSE     = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_SETTLE    = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    state_t             state_r, next_state_s;
    logic               mode_r, dir_r, psen_r, busy_r, done_r, ready_r;
    logic [PHASE_W-1:0] value_r, steps_r, phase_r;
    logic [1:0]         err_r, err_next_s;
    logic [TMO_W-1:0]   tmo_r;
    logic [SET_W-1:0]   set_r;
    logic               accept_s, calc_s, step_s, unlock_s, active_s, range_s, calc_dir_s;
    logic [PHASE_W-1:0] diff_s, mag_s, calc_steps_s;

    // Step planning from the latched command plus next-state and control strobes
    always_comb begin
        next_state_s = state_r;
        err_next_s   = err_r;
        accept_s     = 1'b0;
        calc_s       = 1'b0;
        step_s       = 1'b0;
        unlock_s     = 1'b0;
        active_s     = (state_r == ST_CALC) || (state_r == ST_PULSE) ||
                       (state_r == ST_WAIT_DONE) || (state_r == ST_SETTLE);

        if (value_r >= phase_r) begin
            diff_s = value_r - phase_r;
        end else begin
            diff_s = value_r + P - phase_r;
        end
        mag_s = value_r[PHASE_W-1] ? (~value_r + PHASE_W'(1)) : value_r;

        // Absolute moves take the shorter way round; a tie at P/2 goes up
        if (mode_r) begin
            range_s      = (mag_s >= P);
            calc_steps_s = mag_s;
            calc_dir_s   = ~value_r[PHASE_W-1];
        end else if (diff_s <= HALF_P) begin
            range_s      = (value_r >= P);
            calc_steps_s = diff_s;
            calc_dir_s   = 1'b1;
        end else begin
            range_s      = (value_r >= P);
            calc_steps_s = P - diff_s;
            calc_dir_s   = 1'b0;
        end

        if (active_s && !locked) begin
            unlock_s     = 1'b1;
            err_next_s   = ERR_LOCK;
            next_state_s = ST_DONE;
        end else begin
            case (state_r)
                ST_WAIT_LOCK: begin
                    if (locked) next_state_s = ST_IDLE;
                    else        next_state_s = ST_WAIT_LOCK;
                end
                ST_IDLE: begin
                    if (!locked) begin
                        unlock_s     = 1'b1;
                        next_state_s = ST_WAIT_LOCK;
                    end else if (cmd_valid) begin
                        accept_s     = 1'b1;
                        next_state_s = ST_CALC;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    calc_s = 1'b1;
                    if (range_s) begin
                        err_next_s   = ERR_RANGE;
                        next_state_s = ST_DONE;
                    end else if (calc_steps_s == '0) begin
                        err_next_s   = ERR_OK;
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_PULSE;
                    end
                end
                ST_PULSE: next_state_s = ST_WAIT_DONE;
                ST_WAIT_DONE: begin
                    if (psdone) begin
                        step_s       = 1'b1;
                        next_state_s = ST_SETTLE;
                    end else if (tmo_r == TMO_LAST) begin
                        err_next_s   = ERR_TMO;
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_WAIT_DONE;
                    end
                end
                ST_SETTLE: begin
                    if (set_r != SET_LAST) begin
                        next_state_s = ST_SETTLE;
                    end else if (steps_r != '0) begin
                        next_state_s = ST_PULSE;
                    end else begin
                        err_next_s   = ERR_OK;
                        next_state_s = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!locked) begin
                        unlock_s     = 1'b1;
                        next_state_s = ST_WAIT_LOCK;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                default: next_state_s = ST_WAIT_LOCK;
            endcase
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge psclk) begin
        if (reset) begin
            state_r <= ST_WAIT_LOCK;
            mode_r  <= 1'b0;
            value_r <= '0;
            steps_r <= '0;
            dir_r   <= 1'b0;
            phase_r <= '0;
            tmo_r   <= '0;
            set_r   <= '0;
            psen_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b0;
            err_r   <= ERR_OK;
        end else begin
            state_r <= next_state_s;
            psen_r  <= (next_state_s == ST_PULSE);
            done_r  <= (next_state_s == ST_DONE);
            ready_r <= (next_state_s == ST_IDLE);
            busy_r  <= (next_state_s != ST_WAIT_LOCK) && (next_state_s != ST_IDLE);
            if (next_state_s == ST_DONE) err_r <= err_next_s;
            if (accept_s) begin
                mode_r  <= cmd_mode;
                value_r <= cmd_value;
            end
            if (calc_s) begin
                steps_r <= calc_steps_s;
                dir_r   <= calc_dir_s;
            end else if (step_s) begin
                steps_r <= steps_r - PHASE_W'(1);
            end
            // A relock restarts the MMCM at zero phase
            if (unlock_s) begin
                phase_r <= '0;
            end else if (step_s && dir_r) begin
                phase_r <= (phase_r == P_LAST) ? '0 : phase_r + PHASE_W'(1);
            end else if (step_s) begin
                phase_r <= (phase_r == '0) ? P_LAST : phase_r - PHASE_W'(1);
            end
            if (state_r == ST_PULSE) tmo_r <= TMO_W'(1);
            else if (state_r == ST_WAIT_DONE) tmo_r <= tmo_r + TMO_W'(1);
            if (step_s) set_r <= '0;
            else if (state_r == ST_SETTLE) set_r <= set_r + SET_W'(1);
        end
    end

    assign cmd_ready = ready_r & locked;
    assign psen      = psen_r;
    assign psincdec  = dir_r;
    assign phase_pos = phase_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err_code  = err_r;
endmodule

// File: tb/tb_mmcm_ps_sequencer.sv
// Bench for mmcm_ps_sequencer: table of commands with a scoreboard of expected completions
// and a behavioural MMCM answering psen with psdone three cycles later.
module tb_mmcm_ps_sequencer;
    localparam int PW = 16;
    localparam int P  = 448;

    typedef struct {
        logic          mode;
        logic [PW-1:0] value;
        logic [1:0]    err;
        int            steps;
        logic          dir;
        logic [PW-1:0] phase;
    } vec_t;

    typedef struct {
        logic [1:0]    err;
        int            steps;
        logic          dir;
        logic [PW-1:0] phase;
    } exp_t;

    logic psclk, reset, cmd_valid, cmd_ready, cmd_mode, locked;
    logic psen, psincdec, psdone, busy, done;
    logic [PW-1:0] cmd_value, phase_pos;
    logic [1:0]    err_code;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pend = 0;
    int   withhold_n = 0;
    int   cmd_psen_n = 0;
    int   cmd_inc_n = 0;
    int   cmd_dec_n = 0;
    int   last_psen_cyc = 0;
    logic outstanding = 1'b0;
    logic chk_phase = 1'b0;
    logic model_done = 1'b0;
    logic model_dir = 1'b0;
    logic kick = 1'b0;
    logic [PW-1:0] model_phase = '0;
    exp_t sb_q[$];
    exp_t e;
    vec_t vecs[16];

    assign psdone = model_done | kick;

    mmcm_ps_sequencer dut (
        .psclk(psclk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_value(cmd_value), .locked(locked), .psen(psen),
        .psincdec(psincdec), .psdone(psdone), .phase_pos(phase_pos), .busy(busy),
        .done(done), .err_code(err_code)
    );

    initial begin
        psclk = 1'b0;
        forever #5 psclk = ~psclk;
    end

    always @(posedge psclk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // MMCM model, per-step phase tracking and completion scoreboard
    always @(negedge psclk) begin
        if (chk_phase) check("phase_step", phase_pos, model_phase);
        chk_phase  = 1'b0;
        model_done = 1'b0;
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                model_done  = 1'b1;
                outstanding = 1'b0;
                chk_phase   = 1'b1;
                if (model_dir) model_phase = (model_phase == PW'(P - 1)) ? '0 : model_phase + 1'b1;
                else           model_phase = (model_phase == '0) ? PW'(P - 1) : model_phase - 1'b1;
            end
        end
        if (psen) begin
            check("psen_without_psdone", outstanding, 1'b0);
            outstanding   = 1'b1;
            model_dir     = psincdec;
            cmd_psen_n    = cmd_psen_n + 1;
            if (psincdec) cmd_inc_n = cmd_inc_n + 1;
            else          cmd_dec_n = cmd_dec_n + 1;
            last_psen_cyc = cyc;
            if (cmd_psen_n != withhold_n) pend = 3;
        end
        if (done) begin
            check("done_expected", sb_q.size() > 0, 1'b1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("err_code", err_code, e.err);
                check("phase_at_done", phase_pos, e.phase);
                check("inc_steps", cmd_inc_n, e.dir ? e.steps : 0);
                check("dec_steps", cmd_dec_n, e.dir ? 0 : e.steps);
                check("busy_at_done", busy, 1'b1);
                if (e.err == 2'b10) check("timeout_latency", cyc - last_psen_cyc, 32);
            end
            cmd_psen_n = 0;
            cmd_inc_n  = 0;
            cmd_dec_n  = 0;
        end
    end

    task automatic push_exp(input logic [1:0] err, input int steps, input logic dir, input logic [PW-1:0] phase);
        exp_t x;
        x.err   = err;
        x.steps = steps;
        x.dir   = dir;
        x.phase = phase;
        sb_q.push_back(x);
    endtask

    // Returns at the negedge of the cycle after acceptance (CALC)
    task automatic send(input logic mode, input logic [PW-1:0] value);
        int n;
        @(negedge psclk);
        cmd_mode  = mode;
        cmd_value = value;
        cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge psclk);
            n++;
        end
        check("cmd_accept", cmd_ready, 1'b1);
        @(negedge psclk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_sb();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 5000) begin
            @(negedge psclk);
            n++;
        end
        check("sb_drain", sb_q.size(), 0);
        sb_q.delete();
        @(negedge psclk);
    endtask

    task automatic run_cmd(input vec_t v);
        push_exp(v.err, v.steps, v.dir, v.phase);
        send(v.mode, v.value);
        wait_sb();
    endtask

    initial begin
        int   n;
        vec_t v;
        reset = 1'b1; locked = 1'b0; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_value = '0;

        vecs[0]  = '{1'b0, 16'd100,   2'b00, 100, 1'b1, 16'd100};
        vecs[1]  = '{1'b0, 16'd400,   2'b00, 148, 1'b0, 16'd400};
        vecs[2]  = '{1'b0, 16'd448,   2'b01, 0,   1'b1, 16'd400};
        vecs[3]  = '{1'b1, 16'd448,   2'b01, 0,   1'b1, 16'd400};
        vecs[4]  = '{1'b1, 16'd0,     2'b00, 0,   1'b1, 16'd400};
        vecs[5]  = '{1'b1, 16'd50,    2'b00, 50,  1'b1, 16'd2};
        vecs[6]  = '{1'b0, 16'd226,   2'b00, 224, 1'b1, 16'd226};
        vecs[7]  = '{1'b0, 16'd1,     2'b00, 223, 1'b1, 16'd1};
        vecs[8]  = '{1'b1, 16'hFFFD,  2'b00, 3,   1'b0, 16'd446};
        vecs[9]  = '{1'b0, 16'd446,   2'b00, 0,   1'b1, 16'd446};
        vecs[10] = '{1'b1, 16'hFE40,  2'b01, 0,   1'b1, 16'd446};
        vecs[11] = '{1'b1, 16'h8000,  2'b01, 0,   1'b1, 16'd446};
        vecs[12] = '{1'b0, 16'd0,     2'b00, 2,   1'b1, 16'd0};
        vecs[13] = '{1'b1, 16'hFFFD,  2'b00, 3,   1'b0, 16'd445};
        vecs[14] = '{1'b0, 16'd221,   2'b00, 224, 1'b1, 16'd221};
        vecs[15] = '{1'b0, 16'd447,   2'b00, 222, 1'b0, 16'd447};

        repeat (3) @(negedge psclk);
        check("rst_psen", psen, 1'b0);
        check("rst_psincdec", psincdec, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_err_code", err_code, 2'b00);
        check("rst_phase_pos", phase_pos, 16'd0);
        reset = 1'b0;
        repeat (3) @(negedge psclk);
        check("ready_before_lock", cmd_ready, 1'b0);
        locked = 1'b1;
        repeat (2) @(negedge psclk);
        check("ready_after_lock", cmd_ready, 1'b1);

        for (int i = 0; i < 16; i++) run_cmd(vecs[i]);

        // First psen two cycles after acceptance
        push_exp(2'b00, 2, 1'b1, 16'd1);
        send(1'b1, 16'd2);
        check("busy_in_calc", busy, 1'b1);
        check("ready_in_calc", cmd_ready, 1'b0);
        check("psen_in_calc", psen, 1'b0);
        @(negedge psclk);
        check("psen_cycle2", psen, 1'b1);
        check("psincdec_cycle2", psincdec, 1'b1);
        wait_sb();

        // Range error completes two cycles after acceptance
        push_exp(2'b01, 0, 1'b1, 16'd1);
        send(1'b0, 16'd500);
        @(negedge psclk);
        check("range_done_cycle2", done, 1'b1);
        wait_sb();

        // Stray psdone while idle
        kick = 1'b1;
        @(negedge psclk);
        kick = 1'b0;
        repeat (2) @(negedge psclk);
        check("psdone_idle_ignored", phase_pos, 16'd1);

        // psdone withheld on the second step
        withhold_n = 2;
        push_exp(2'b10, 2, 1'b1, 16'd2);
        send(1'b1, 16'd5);
        wait_sb();
        withhold_n  = 0;
        outstanding = 1'b0;

        // Lock lost while waiting for the third psdone
        push_exp(2'b11, 3, 1'b1, 16'd0);
        send(1'b1, 16'd20);
        n = 0;
        while (cmd_psen_n < 3 && n < 200) begin
            @(negedge psclk);
            n++;
        end
        check("lock_reach_step3", cmd_psen_n, 3);
        @(negedge psclk);
        locked = 1'b0; pend = 0; outstanding = 1'b0; model_phase = '0;
        wait_sb();
        repeat (4) @(negedge psclk);
        check("ready_while_unlocked", cmd_ready, 1'b0);
        check("psen_after_abort", cmd_psen_n, 0);
        check("phase_while_unlocked", phase_pos, 16'd0);
        check("busy_while_unlocked", busy, 1'b0);
        locked = 1'b1;
        repeat (2) @(negedge psclk);
        check("ready_after_relock", cmd_ready, 1'b1);

        v = '{1'b0, 16'd10, 2'b00, 10, 1'b1, 16'd10};
        run_cmd(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
